// File: rtl/gcm_out_collector_if.sv
// rtl/gcm_out_collector_if.sv - GCM output capture and egress stream signals
// master: collector view (captures gcm strobes, drives egress); slave: surrounding logic view.
interface gcm_out_collector_if #(
  parameter int BLK_BITS = 128
);
  logic [BLK_BITS-1:0] gcm_out_blk;
  logic                gcm_out_store_blk;
  logic                gcm_done;
  logic [BLK_BITS-1:0] out_blk;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  gcm_out_blk, gcm_out_store_blk, gcm_done, out_ready,
    output out_blk, out_last, out_valid
  );

  modport slave (
    output gcm_out_blk, gcm_out_store_blk, gcm_done, out_ready,
    input  out_blk, out_last, out_valid
  );
endinterface

// File: rtl/gcm_out_collector.sv
// rtl/gcm_out_collector.sv - buffers gcm output blocks and re-presents them as a valid/ready stream
// Optional tag comparison on the last entry is enabled by defining GCM_OUT_TAG_CMP_EN.
module gcm_out_collector #(
  parameter int BLK_BITS   = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_FREE = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  gcm_out_collector_if.master           bus,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          proto_err
`ifdef GCM_OUT_TAG_CMP_EN
  ,
  input  logic [BLK_BITS-1:0]           exp_tag,
  output logic                          tag_checked,
  output logic                          tag_match
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [BLK_BITS-1:0]   mem_blk [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;

  always_comb begin
    full = (count == CW'(FIFO_DEPTH));
    pop  = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a strobe when the head leaves in the same cycle.
    push = bus.gcm_out_store_blk && (!full || pop);
  end

  assign almost_full = ((CW'(FIFO_DEPTH) - count) <= CW'(AFULL_FREE));

  // Storage carries no reset; the head is masked to zero while nothing is queued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_blk[wr_ptr]  <= bus.gcm_out_blk;
      mem_last[wr_ptr] <= bus.gcm_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.gcm_out_store_blk && full && !pop) overflow <= 1'b1;
      if (bus.gcm_done && !bus.gcm_out_store_blk) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = STREAM;
      STREAM:  if (pop && !push && count == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == STREAM);
    bus.out_blk   = '0;
    bus.out_last  = 1'b0;
    if (state_q == STREAM) begin
      bus.out_blk  = mem_blk[rd_ptr];
      bus.out_last = mem_last[rd_ptr];
    end
  end

`ifdef GCM_OUT_TAG_CMP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_checked <= 1'b0;
      tag_match   <= 1'b0;
    end else begin
      tag_checked <= pop && bus.out_last;
      if (pop && bus.out_last) tag_match <= (bus.out_blk == exp_tag);
    end
  end
`endif

endmodule
